// File: rtl/jk_bank_driver.sv
`timescale 1ns/1ps
// jk_bank_driver
// Excitation driver for a bank of WIDTH JK flip-flops. A target value is
// accepted over a valid/ready handshake, per-bit J/K excitation is computed
// from the bank's current Q, driven for one cycle, and the bank's Q feedback
// is then checked against the target. On a mismatch the drive is retried up
// to MAX_RETRY extra times before an error is reported.
//
// Ports:
//   Clk        in   1      system clock, rising edge
//   Rst        in   1      asynchronous active-high reset
//   Req_valid  in   1      request present
//   Req_ready  out  1      request can be accepted (IDLE only)
//   Req_data   in   WIDTH  target value for the bank
//   Q_fb       in   WIDTH  current Q of the JK bank
//   J          out  WIDTH  J inputs to the bank (registered)
//   K          out  WIDTH  K inputs to the bank (registered)
//   Busy       out  1      high while driving or checking
//   Done       out  1      one-cycle pulse: bank matched target
//   Err        out  1      one-cycle pulse: retries exhausted
module jk_bank_driver #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Req_valid,
  output logic             Req_ready,
  input  logic [WIDTH-1:0] Req_data,
  input  logic [WIDTH-1:0] Q_fb,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  // Retry counter only has to reach MAX_RETRY; keep at least one bit so a
  // MAX_RETRY of 0 still yields a legal vector.
  localparam int RW_RAW = $clog2(MAX_RETRY + 1);
  localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state;
  logic [RW-1:0]    retry;
  logic [WIDTH-1:0] target;

  // Excitation: set only bits that are 0 but should be 1, clear only bits
  // that are 1 but should be 0. The two masks are disjoint by construction,
  // so J and K are never both high on a bit, and matching bits hold.
  function automatic logic [WIDTH-1:0] set_mask(input logic [WIDTH-1:0] tgt,
                                                input logic [WIDTH-1:0] q);
    return tgt & ~q;
  endfunction

  function automatic logic [WIDTH-1:0] clr_mask(input logic [WIDTH-1:0] tgt,
                                                input logic [WIDTH-1:0] q);
    return ~tgt & q;
  endfunction

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      Req_ready <= 1'b1;
      J         <= '0;
      K         <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      retry     <= '0;
      target    <= '0;
    end else begin
      // Done/Err are single-cycle pulses unless re-asserted below.
      Done <= 1'b0;
      Err  <= 1'b0;
      case (state)
        IDLE: begin
          if (Req_valid) begin
            target    <= Req_data;
            J         <= set_mask(Req_data, Q_fb);
            K         <= clr_mask(Req_data, Q_fb);
            retry     <= '0;
            state     <= DRIVE;
            Busy      <= 1'b1;
            Req_ready <= 1'b0;
          end else begin
            J <= '0;
            K <= '0;
          end
        end
        DRIVE: begin
          // Bank captures J/K at this edge; release them for the check cycle.
          J     <= '0;
          K     <= '0;
          state <= CHECK;
        end
        CHECK: begin
          if (Q_fb == target) begin
            Done      <= 1'b1;
            state     <= IDLE;
            Busy      <= 1'b0;
            Req_ready <= 1'b1;
          end else if (retry < RETRY_LIMIT) begin
            J     <= set_mask(target, Q_fb);
            K     <= clr_mask(target, Q_fb);
            retry <= retry + RW'(1);
            state <= DRIVE;
          end else begin
            Err       <= 1'b1;
            state     <= IDLE;
            Busy      <= 1'b0;
            Req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          J         <= '0;
          K         <= '0;
          Busy      <= 1'b0;
          Req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
`timescale 1ns/1ps
// Testbench for jk_bank_driver: a behavioural JK bank closes the loop on
// Q_fb, an acceptor pushes the expected outcome of each accepted request,
// and a monitor compares the DUT's drive pattern and completion pulses.
module tb_jk_bank_driver;

  localparam int WIDTH     = 8;
  localparam int MAX_RETRY = 3;

  logic             Clk;
  logic             Rst;
  logic             Req_valid;
  logic             Req_ready;
  logic [WIDTH-1:0] Req_data;
  logic [WIDTH-1:0] Q_fb;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             Busy;
  logic             Done;
  logic             Err;

  jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
    .Clk(Clk), .Rst(Rst), .Req_valid(Req_valid), .Req_ready(Req_ready),
    .Req_data(Req_data), .Q_fb(Q_fb), .J(J), .K(K),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Behavioural JK bank with optional stuck-at-0 bits.
  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] stuck;
  logic             load_en;
  logic [WIDTH-1:0] load_val;

  always @(posedge Clk) begin
    if (load_en) bank_q <= load_val & ~stuck;
    else         bank_q <= ((J & ~bank_q) | (~K & bank_q)) & ~stuck;
  end
  assign Q_fb = bank_q;

  // Expected outcome of one request, derived from the write rules:
  // after any drive the healthy bits equal the target and stuck bits are 0.
  typedef struct {
    logic             ok;
    logic [WIDTH-1:0] q;
    int               drives;
    logic [WIDTH-1:0] j1, k1, jr, kr;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [WIDTH-1:0] tgt,
                                 input logic [WIDTH-1:0] q0,
                                 input logic [WIDTH-1:0] stk);
    exp_t e;
    logic [WIDTH-1:0] q1;
    q1       = tgt & ~stk;
    e.ok     = (q1 == tgt);
    e.q      = q1;
    e.drives = e.ok ? 1 : MAX_RETRY + 1;
    e.j1     = tgt & ~q0;
    e.k1     = ~tgt & q0;
    e.jr     = tgt & ~q1;
    e.kr     = ~tgt & q1;
    return e;
  endfunction

  // Acceptor: a handshake at this edge means a request entered the DUT.
  always @(posedge Clk) begin
    if (!Rst && Req_valid && Req_ready)
      sb.push_back(model(Req_data, bank_q, stuck));
  end

  // Monitor: samples on the falling edge.
  int   busy_cnt  = 0;
  logic prev_busy = 1'b0;
  exp_t mon_e;

  always @(negedge Clk) begin
    if (Rst) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      chk("jk_exclusive", 32'(J & K), 32'h0);
      chk("ready_vs_busy", 32'(Req_ready), 32'(!Busy));
      if (Done && Err) fail_now("done_err_both");
      if (Busy) begin
        busy_cnt++;
        if (sb.size() == 0) begin
          fail_now("busy_without_request");
        end else if (busy_cnt % 2 == 1) begin
          chk("drive_j", 32'(J), 32'((busy_cnt == 1) ? sb[0].j1 : sb[0].jr));
          chk("drive_k", 32'(K), 32'((busy_cnt == 1) ? sb[0].k1 : sb[0].kr));
        end else begin
          chk("check_j_zero", 32'(J | K), 32'h0);
        end
      end
      if (Done || Err) begin
        if (sb.size() == 0) begin
          fail_now("spurious_done_err");
        end else begin
          mon_e = sb.pop_front();
          chk("done_flag", 32'(Done), 32'(mon_e.ok));
          chk("err_flag", 32'(Err), 32'(!mon_e.ok));
          chk("busy_cycles", 32'(busy_cnt), 32'(2 * mon_e.drives));
          chk("pulse_after_busy", 32'(prev_busy), 32'h1);
          chk("bank_q", 32'(bank_q), 32'(mon_e.q));
        end
        busy_cnt = 0;
      end
      prev_busy = Busy;
    end
  end

  // Stimulus helpers.
  task automatic wait_accept();
    for (int i = 0; i < 50; i++) begin
      @(posedge Clk);
      if (Req_ready) return;
    end
    fail_now("accept_timeout");
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    @(negedge Clk);
    Req_valid = 1'b1;
    Req_data  = d;
    wait_accept();
    #1 Req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (sb.size() == 0 && Req_ready) begin
        @(negedge Clk);
        return;
      end
    end
    fail_now("idle_timeout");
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    @(negedge Clk);
    load_en  = 1'b1;
    load_val = v;
    @(negedge Clk);
    load_en  = 1'b0;
  endtask

  initial begin
    Rst       = 1'b1;
    Req_valid = 1'b0;
    Req_data  = '0;
    stuck     = '0;
    load_en   = 1'b0;
    load_val  = '0;
    #1;
    chk("rst_ready", 32'(Req_ready), 32'h1);
    chk("rst_j", 32'(J), 32'h0);
    chk("rst_k", 32'(K), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_done_err", 32'({Done, Err}), 32'h0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst = 1'b0;

    // Basic set.
    load(8'h00);
    send(8'hA5);
    wait_idle();
    chk("basic_q", 32'(bank_q), 32'hA5);

    // Mixed set/clear.
    load(8'hFF);
    send(8'h0F);
    wait_idle();
    chk("mixed_q", 32'(bank_q), 32'h0F);

    // No change still takes the full DRIVE/CHECK path.
    load(8'h3C);
    send(8'h3C);
    wait_idle();
    chk("nochange_q", 32'(bank_q), 32'h3C);

    // Stuck bit 0 forces all retries and an error.
    stuck = 8'h01;
    load(8'h00);
    send(8'h01);
    wait_idle();
    chk("stuck_q", 32'(bank_q), 32'h00);
    stuck = 8'h00;

    // Back-to-back with Req_valid held high.
    load(8'h00);
    @(negedge Clk);
    Req_valid = 1'b1;
    Req_data  = 8'h11;
    wait_accept();
    #1 Req_data = 8'h22;
    wait_accept();
    #1 Req_valid = 1'b0;
    wait_idle();
    chk("b2b_q", 32'(bank_q), 32'h22);

    // Reset during DRIVE aborts the request asynchronously.
    load(8'h00);
    send(8'hF0);
    #1 Rst = 1'b1;
    #1;
    chk("arst_j", 32'(J), 32'h0);
    chk("arst_k", 32'(K), 32'h0);
    chk("arst_busy", 32'(Busy), 32'h0);
    sb.delete();
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst = 1'b0;
    #1 chk("arst_ready", 32'(Req_ready), 32'h1);
    repeat (4) @(negedge Clk);
    send(8'h0F);
    wait_idle();
    chk("arst_after_q", 32'(bank_q), 32'h0F);

    // Randomized requests, occasional stuck bits and bank preloads.
    for (int n = 0; n < 30; n++) begin
      logic [WIDTH-1:0] d;
      stuck = ($urandom_range(0, 3) == 0) ? WIDTH'(1 << $urandom_range(0, WIDTH - 1)) : '0;
      if ($urandom_range(0, 1) == 1) load(WIDTH'($urandom_range(0, 255)));
      else @(negedge Clk);
      d = ($urandom_range(0, 4) == 0) ? bank_q : WIDTH'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      send(d);
      wait_idle();
    end
    stuck = '0;

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
